// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the three buses around mem_arbiter: fetch port
//               (imem_*), data port (dmem_*) and external memory (mem_*).
//               master : the arbiter's view (takes requests, drives memory)
//               slave  : the environment's view (core + memory model)
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   imem_rd_addr/enable -> arbiter      imem_rd_data/ready/err <- arbiter
//   dmem_addr/rd/wr/wr_data/wr_strb ->  dmem_rd_data/ready/err <- arbiter
//   mem_addr/rd/wr/wr_data/wr_strb <-   mem_rd_data/mem_ready  -> arbiter
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // fetch port
  logic [ADDR_W-1:0] imem_rd_addr;
  logic              imem_rd_enable;
  logic [DATA_W-1:0] imem_rd_data;
  logic              imem_rd_ready;
  logic              imem_err;

  // data port
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_rd_enable;
  logic              dmem_wr_enable;
  logic [DATA_W-1:0] dmem_wr_data;
  logic [STRB_W-1:0] dmem_wr_strb;
  logic [DATA_W-1:0] dmem_rd_data;
  logic              dmem_ready;
  logic              dmem_err;

  // external memory
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_enable;
  logic              mem_wr_enable;
  logic [DATA_W-1:0] mem_wr_data;
  logic [STRB_W-1:0] mem_wr_strb;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_ready;

  modport master (
    input  imem_rd_addr, imem_rd_enable,
    output imem_rd_data, imem_rd_ready, imem_err,
    input  dmem_addr, dmem_rd_enable, dmem_wr_enable, dmem_wr_data, dmem_wr_strb,
    output dmem_rd_data, dmem_ready, dmem_err,
    output mem_addr, mem_rd_enable, mem_wr_enable, mem_wr_data, mem_wr_strb,
    input  mem_rd_data, mem_ready
  );

  modport slave (
    output imem_rd_addr, imem_rd_enable,
    input  imem_rd_data, imem_rd_ready, imem_err,
    output dmem_addr, dmem_rd_enable, dmem_wr_enable, dmem_wr_data, dmem_wr_strb,
    input  dmem_rd_data, dmem_ready, dmem_err,
    input  mem_addr, mem_rd_enable, mem_wr_enable, mem_wr_data, mem_wr_strb,
    output mem_rd_data, mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-ported memory between the instruction
//               fetch port (read-only) and the data port (read/write).
//               One transaction at a time: IDLE -> BUSY_I/BUSY_D -> DONE.
//               Data has priority; fetch is forced after STARVE_LIMIT data
//               grants made while it waited. A BUSY timeout completes the
//               transaction with err=1 instead of hanging.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - mem_arbiter_if.master (fetch, data and memory buses)
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mem_arbiter_if.master bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SC_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);
  // Abort on the BUSY cycle whose increment would make the timer reach TIMEOUT
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SC_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_rd_enable_q, mem_rd_enable_d;
  logic               mem_wr_enable_q, mem_wr_enable_d;
  logic [DATA_W-1:0]  mem_wr_data_q, mem_wr_data_d;
  logic [STRB_W-1:0]  mem_wr_strb_q, mem_wr_strb_d;

  logic [DATA_W-1:0]  imem_rd_data_q, imem_rd_data_d;
  logic               imem_rd_ready_q, imem_rd_ready_d;
  logic               imem_err_q, imem_err_d;
  logic [DATA_W-1:0]  dmem_rd_data_q, dmem_rd_data_d;
  logic               dmem_ready_q, dmem_ready_d;
  logic               dmem_err_q, dmem_err_d;

  logic               data_req;
  logic               fetch_wins;

  always_comb begin
    state_d         = state_q;
    starve_cnt_d    = starve_cnt_q;
    timer_d         = timer_q;
    mem_addr_d      = mem_addr_q;
    mem_rd_enable_d = mem_rd_enable_q;
    mem_wr_enable_d = mem_wr_enable_q;
    mem_wr_data_d   = mem_wr_data_q;
    mem_wr_strb_d   = mem_wr_strb_q;
    imem_rd_data_d  = imem_rd_data_q;
    dmem_rd_data_d  = dmem_rd_data_q;
    // completion flags are single-cycle pulses
    imem_rd_ready_d = 1'b0;
    imem_err_d      = 1'b0;
    dmem_ready_d    = 1'b0;
    dmem_err_d      = 1'b0;

    data_req   = bus.dmem_wr_enable | bus.dmem_rd_enable;
    fetch_wins = bus.imem_rd_enable & (~data_req | (starve_cnt_q == STARVE_MAX));

    case (state_q)
      IDLE: begin
        if (fetch_wins) begin
          state_d         = BUSY_I;
          starve_cnt_d    = '0;
          timer_d         = '0;
          mem_addr_d      = bus.imem_rd_addr;
          mem_rd_enable_d = 1'b1;
          mem_wr_enable_d = 1'b0;
          mem_wr_data_d   = '0;
          mem_wr_strb_d   = '0;
        end else if (data_req) begin
          state_d         = BUSY_D;
          timer_d         = '0;
          mem_addr_d      = bus.dmem_addr;
          // write takes precedence when both enables are raised
          mem_wr_enable_d = bus.dmem_wr_enable;
          mem_rd_enable_d = ~bus.dmem_wr_enable;
          mem_wr_data_d   = bus.dmem_wr_data;
          mem_wr_strb_d   = bus.dmem_wr_strb;
          if (bus.imem_rd_enable && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
          end
        end
      end

      BUSY_I, BUSY_D: begin
        timer_d = timer_q + TMR_W'(1);
        if (bus.mem_ready) begin
          state_d         = DONE;
          timer_d         = '0;
          mem_rd_enable_d = 1'b0;
          mem_wr_enable_d = 1'b0;
          if (state_q == BUSY_I) begin
            imem_rd_ready_d = 1'b1;
            imem_rd_data_d  = bus.mem_rd_data;
          end else begin
            dmem_ready_d = 1'b1;
            if (!mem_wr_enable_q) begin
              dmem_rd_data_d = bus.mem_rd_data;
            end
          end
        end else if (timer_q == TMR_LAST) begin
          state_d         = DONE;
          timer_d         = '0;
          mem_rd_enable_d = 1'b0;
          mem_wr_enable_d = 1'b0;
          if (state_q == BUSY_I) begin
            imem_rd_ready_d = 1'b1;
            imem_err_d      = 1'b1;
            imem_rd_data_d  = '0;
          end else begin
            dmem_ready_d   = 1'b1;
            dmem_err_d     = 1'b1;
            dmem_rd_data_d = '0;
          end
        end
      end

      DONE: begin
        // ready pulse is visible this cycle; no arbitration until IDLE
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      starve_cnt_q    <= '0;
      timer_q         <= '0;
      mem_addr_q      <= '0;
      mem_rd_enable_q <= 1'b0;
      mem_wr_enable_q <= 1'b0;
      mem_wr_data_q   <= '0;
      mem_wr_strb_q   <= '0;
      imem_rd_data_q  <= '0;
      imem_rd_ready_q <= 1'b0;
      imem_err_q      <= 1'b0;
      dmem_rd_data_q  <= '0;
      dmem_ready_q    <= 1'b0;
      dmem_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      starve_cnt_q    <= starve_cnt_d;
      timer_q         <= timer_d;
      mem_addr_q      <= mem_addr_d;
      mem_rd_enable_q <= mem_rd_enable_d;
      mem_wr_enable_q <= mem_wr_enable_d;
      mem_wr_data_q   <= mem_wr_data_d;
      mem_wr_strb_q   <= mem_wr_strb_d;
      imem_rd_data_q  <= imem_rd_data_d;
      imem_rd_ready_q <= imem_rd_ready_d;
      imem_err_q      <= imem_err_d;
      dmem_rd_data_q  <= dmem_rd_data_d;
      dmem_ready_q    <= dmem_ready_d;
      dmem_err_q      <= dmem_err_d;
    end
  end

  assign bus.imem_rd_data  = imem_rd_data_q;
  assign bus.imem_rd_ready = imem_rd_ready_q;
  assign bus.imem_err      = imem_err_q;
  assign bus.dmem_rd_data  = dmem_rd_data_q;
  assign bus.dmem_ready    = dmem_ready_q;
  assign bus.dmem_err      = dmem_err_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_rd_enable = mem_rd_enable_q;
  assign bus.mem_wr_enable = mem_wr_enable_q;
  assign bus.mem_wr_data   = mem_wr_data_q;
  assign bus.mem_wr_strb   = mem_wr_strb_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Tasks push expected
//               grants and completions into queues; monitors pop and compare
//               when the DUT raises a memory enable or a ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } grant_t;

  typedef struct packed {
    logic        fetch;
    logic        err;
    logic [31:0] data;
  } cpl_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  grant_t grant_q[$];
  cpl_t   cpl_q[$];

  // memory model controls
  bit          mem_resp_en;
  int          mem_lat;
  logic [31:0] rdata_base;
  logic [31:0] last_dmem;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory responder: mem_ready after mem_lat cycles of an active enable
  initial begin : responder
    int cnt;
    cnt = 0;
    bus.mem_ready   = 1'b0;
    bus.mem_rd_data = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_resp_en) begin
        if ((bus.mem_rd_enable || bus.mem_wr_enable) && !bus.mem_ready) begin
          if (cnt == mem_lat) begin
            bus.mem_ready   = 1'b1;
            bus.mem_rd_data = rdata_base ^ bus.mem_addr;
            cnt = 0;
          end else begin
            cnt++;
          end
        end else begin
          bus.mem_ready   = 1'b0;
          bus.mem_rd_data = 32'hBAD0_BAD0;
          cnt = 0;
        end
      end
    end
  end

  // grant and completion monitors
  initial begin : monitor
    logic   prev_en;
    grant_t g;
    cpl_t   c;
    logic [3:0]  exp_f, got_f;
    logic [31:0] got_d;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus.mem_rd_enable || bus.mem_wr_enable) && !prev_en) begin
        checks++;
        if (grant_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected addr=%h", bus.mem_addr);
        end else begin
          g = grant_q.pop_front();
          if (bus.mem_addr !== g.addr || bus.mem_wr_enable !== g.wr ||
              bus.mem_rd_enable !== !g.wr || bus.mem_wr_data !== g.wdata ||
              bus.mem_wr_strb !== g.strb) begin
            errors++;
            $display("FAIL grant got addr=%h rd=%b wr=%b wd=%h strb=%b want addr=%h wr=%b wd=%h strb=%b",
                     bus.mem_addr, bus.mem_rd_enable, bus.mem_wr_enable, bus.mem_wr_data,
                     bus.mem_wr_strb, g.addr, g.wr, g.wdata, g.strb);
          end
        end
      end
      prev_en = bus.mem_rd_enable || bus.mem_wr_enable;

      if (bus.imem_rd_ready || bus.dmem_ready) begin
        checks++;
        if (cpl_q.size() == 0) begin
          errors++;
          $display("FAIL completion_unexpected iready=%b dready=%b", bus.imem_rd_ready, bus.dmem_ready);
        end else begin
          c = cpl_q.pop_front();
          exp_f = c.fetch ? {1'b1, c.err, 2'b00} : {2'b00, 1'b1, c.err};
          got_f = {bus.imem_rd_ready, bus.imem_err, bus.dmem_ready, bus.dmem_err};
          got_d = c.fetch ? bus.imem_rd_data : bus.dmem_rd_data;
          if (got_f !== exp_f || got_d !== c.data) begin
            errors++;
            $display("FAIL completion got flags(ir,ie,dr,de)=%b data=%h want flags=%b data=%h",
                     got_f, got_d, exp_f, c.data);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    logic [255:0] v;
    v = {bus.imem_rd_data, bus.imem_rd_ready, bus.imem_err, bus.dmem_rd_data, bus.dmem_ready,
         bus.dmem_err, bus.mem_addr, bus.mem_rd_enable, bus.mem_wr_enable, bus.mem_wr_data,
         bus.mem_wr_strb};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s outputs=%h want 0", name, v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch_only();
    bit seen, done;
    int lat_cyc;
    rdata_base = 32'h13 ^ 32'h100;
    mem_lat    = 2;
    grant_q.push_back(grant_t'{addr: 32'h100, wr: 1'b0, wdata: 32'h0, strb: 4'h0});
    cpl_q.push_back(cpl_t'{fetch: 1'b1, err: 1'b0, data: 32'h13});
    bus.imem_rd_addr   = 32'h100;
    bus.imem_rd_enable = 1'b1;
    seen = 0; done = 0; lat_cyc = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (seen) lat_cyc++;
      if (bus.mem_rd_enable && !seen) seen = 1;
      if (bus.imem_rd_ready) begin
        done = 1;
        bus.imem_rd_enable = 1'b0;
      end
    end
    checks++;
    if (!done || lat_cyc != 3) begin
      errors++;
      $display("FAIL fetch_latency done=%0d cycles=%0d want 3", done, lat_cyc);
    end
  endtask

  task automatic test_simultaneous();
    int d_cyc, i_cyc;
    logic [1:0] sc_after;
    bit sc_seen;
    rdata_base = 32'h5000_0000;
    mem_lat    = 0;
    grant_q.push_back(grant_t'{addr: 32'h2000, wr: 1'b0, wdata: 32'h0, strb: 4'h0});
    grant_q.push_back(grant_t'{addr: 32'h180,  wr: 1'b0, wdata: 32'h0, strb: 4'h0});
    cpl_q.push_back(cpl_t'{fetch: 1'b0, err: 1'b0, data: 32'h5000_2000});
    cpl_q.push_back(cpl_t'{fetch: 1'b1, err: 1'b0, data: 32'h5000_0180});
    last_dmem = 32'h5000_2000;
    bus.imem_rd_addr   = 32'h180;
    bus.imem_rd_enable = 1'b1;
    bus.dmem_addr      = 32'h2000;
    bus.dmem_rd_enable = 1'b1;
    d_cyc = -1; i_cyc = -1; sc_seen = 0; sc_after = 2'd0;
    for (int i = 0; i < 50 && (d_cyc < 0 || i_cyc < 0); i++) begin
      @(negedge clk);
      if (bus.mem_rd_enable && !sc_seen) begin
        sc_seen  = 1;
        sc_after = 2'(dut.starve_cnt_q);
      end
      if (bus.dmem_ready) begin d_cyc = i; bus.dmem_rd_enable = 1'b0; end
      if (bus.imem_rd_ready) begin i_cyc = i; bus.imem_rd_enable = 1'b0; end
    end
    checks++;
    if (d_cyc < 0 || i_cyc < 0 || d_cyc >= i_cyc) begin
      errors++;
      $display("FAIL simul_order data_cyc=%0d fetch_cyc=%0d want data first", d_cyc, i_cyc);
    end
    checks++;
    if (sc_after !== 2'd1) begin
      errors++;
      $display("FAIL simul_starve_cnt got=%0d want 1", sc_after);
    end
  endtask

  task automatic test_starvation();
    int nd, ni;
    logic [31:0] a;
    rdata_base = 32'h0077_0000;
    mem_lat    = 1;
    // D1..D4, forced I1, D5 (fetch idle), D6..D9, forced I2
    for (int k = 0; k < 9; k++) begin
      a = 32'h3000 + 32'(4 * k);
      if (k == 4) begin
        grant_q.push_back(grant_t'{addr: 32'h500, wr: 1'b0, wdata: 32'h0, strb: 4'h0});
        cpl_q.push_back(cpl_t'{fetch: 1'b1, err: 1'b0, data: rdata_base ^ 32'h500});
      end
      grant_q.push_back(grant_t'{addr: a, wr: 1'b0, wdata: 32'h0, strb: 4'h0});
      cpl_q.push_back(cpl_t'{fetch: 1'b0, err: 1'b0, data: rdata_base ^ a});
      last_dmem = rdata_base ^ a;
    end
    grant_q.push_back(grant_t'{addr: 32'h504, wr: 1'b0, wdata: 32'h0, strb: 4'h0});
    cpl_q.push_back(cpl_t'{fetch: 1'b1, err: 1'b0, data: rdata_base ^ 32'h504});

    bus.imem_rd_addr   = 32'h500;
    bus.imem_rd_enable = 1'b1;
    bus.dmem_addr      = 32'h3000;
    bus.dmem_rd_enable = 1'b1;
    nd = 0; ni = 0;
    for (int i = 0; i < 400 && !(nd == 9 && ni == 2); i++) begin
      @(negedge clk);
      if (bus.dmem_ready) begin
        nd++;
        if (nd == 9) bus.dmem_rd_enable = 1'b0;
        else bus.dmem_addr = 32'h3000 + 32'(4 * nd);
        if (nd == 5) begin
          bus.imem_rd_addr   = 32'h504;
          bus.imem_rd_enable = 1'b1;
        end
      end
      if (bus.imem_rd_ready) begin
        ni++;
        bus.imem_rd_enable = 1'b0;
      end
    end
    checks++;
    if (nd != 9 || ni != 2) begin
      errors++;
      $display("FAIL starve_counts data=%0d fetch=%0d want 9 and 2", nd, ni);
    end
  endtask

  task automatic test_write();
    bit done;
    mem_lat = 1;
    grant_q.push_back(grant_t'{addr: 32'h40, wr: 1'b1, wdata: 32'hDEADBEEF, strb: 4'b0011});
    cpl_q.push_back(cpl_t'{fetch: 1'b0, err: 1'b0, data: last_dmem});
    bus.dmem_addr      = 32'h40;
    bus.dmem_wr_data   = 32'hDEADBEEF;
    bus.dmem_wr_strb   = 4'b0011;
    bus.dmem_rd_enable = 1'b1;
    bus.dmem_wr_enable = 1'b1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.dmem_ready) begin
        done = 1;
        bus.dmem_rd_enable = 1'b0;
        bus.dmem_wr_enable = 1'b0;
        bus.dmem_wr_data   = 32'h0;
        bus.dmem_wr_strb   = 4'h0;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL write_wait got no dmem_ready want pulse");
    end
  endtask

  task automatic test_timeout();
    int busy_cyc, spurious;
    bit done;
    mem_resp_en   = 1'b0;
    bus.mem_ready = 1'b0;
    grant_q.push_back(grant_t'{addr: 32'h80, wr: 1'b0, wdata: 32'h0, strb: 4'h0});
    cpl_q.push_back(cpl_t'{fetch: 1'b0, err: 1'b1, data: 32'h0});
    last_dmem = 32'h0;
    bus.dmem_addr      = 32'h80;
    bus.dmem_rd_enable = 1'b1;
    busy_cyc = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_rd_enable) busy_cyc++;
      if (bus.dmem_ready) begin
        done = 1;
        bus.dmem_rd_enable = 1'b0;
      end
    end
    checks++;
    if (!done || busy_cyc != 8) begin
      errors++;
      $display("FAIL timeout_busy done=%0d busy_cycles=%0d want 8", done, busy_cyc);
    end
    // late memory response while idle must be ignored
    repeat (2) @(negedge clk);
    bus.mem_ready   = 1'b1;
    bus.mem_rd_data = 32'h1234_5678;
    @(negedge clk);
    bus.mem_ready   = 1'b0;
    spurious = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.imem_rd_ready || bus.dmem_ready || bus.mem_rd_enable || bus.mem_wr_enable) spurious++;
    end
    checks++;
    if (spurious != 0 || bus.dmem_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL timeout_late_ready events=%0d dmem_rd_data=%h want 0 and 0", spurious, bus.dmem_rd_data);
    end
    mem_resp_en = 1'b1;
  endtask

  task automatic test_reset_mid_busy();
    bit seen, done;
    int stray;
    rdata_base = 32'h00AB_0000;
    mem_lat    = 5;
    grant_q.push_back(grant_t'{addr: 32'h300, wr: 1'b0, wdata: 32'h0, strb: 4'h0});
    bus.imem_rd_addr   = 32'h300;
    bus.imem_rd_enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_rd_enable) seen = 1;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_busy");
    bus.imem_rd_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.imem_rd_ready) stray++;
    end
    checks++;
    if (!seen || stray != 0) begin
      errors++;
      $display("FAIL reset_lost_txn granted=%0d ready_pulses=%0d want 1 and 0", seen, stray);
    end
    // fresh request after reset
    mem_lat = 1;
    grant_q.push_back(grant_t'{addr: 32'h304, wr: 1'b0, wdata: 32'h0, strb: 4'h0});
    cpl_q.push_back(cpl_t'{fetch: 1'b1, err: 1'b0, data: 32'h00AB_0304});
    bus.imem_rd_addr   = 32'h304;
    bus.imem_rd_enable = 1'b1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.imem_rd_ready) begin
        done = 1;
        bus.imem_rd_enable = 1'b0;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL reset_recover got no imem_rd_ready want pulse");
    end
  endtask

  initial begin : main
    checks = 0;
    errors = 0;
    mem_resp_en = 1'b1;
    mem_lat     = 0;
    rdata_base  = 32'h0;
    last_dmem   = 32'h0;
    reset       = 1'b1;
    bus.imem_rd_addr   = 32'h0;
    bus.imem_rd_enable = 1'b0;
    bus.dmem_addr      = 32'h0;
    bus.dmem_rd_enable = 1'b0;
    bus.dmem_wr_enable = 1'b0;
    bus.dmem_wr_data   = 32'h0;
    bus.dmem_wr_strb   = 4'h0;

    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_write();
    test_timeout();
    test_reset_mid_busy();

    repeat (3) @(negedge clk);
    checks++;
    if (grant_q.size() != 0 || cpl_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations grants=%0d completions=%0d want 0 and 0",
               grant_q.size(), cpl_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
